i2c_tx_sched: RTL and testbench

I2C_TX_SCHED -- requirements
Module: i2c_tx_sched

---
 rtl/i2c_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_i2c_tx_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tx_sched.sv
// i2c_tx_sched: two-requester round-robin scheduler driving an I2C byte transmitter.
// Optional ack watchdog (status 11) is built when I2C_TX_SCHED_TIMEOUT_EN is defined.

module i2c_tx_sched_lane (
  input  logic        gsel,
  input  logic        fsel,
  input  logic        pop_en,
  input  logic        done_en,
  input  logic [6:0]  addr,
  input  logic [2:0]  len,
  input  logic [7:0]  pdata,
  output logic [17:0] fields,
  output logic        pop,
  output logic        done
);
  // Unselected lanes contribute zero so the top can OR-reduce the fields.
  assign fields = fsel ? {addr, len, pdata} : 18'd0;
  assign pop    = gsel & pop_en;
  assign done   = gsel & done_en;
endmodule

module i2c_tx_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [13:0] addr,
  input  logic [5:0]  len,
  input  logic [15:0] pdata,
  output logic [1:0]  pop,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  status,
  output logic        busy,
  output logic        tx_n,
  output logic [7:0]  tx_data,
  input  logic        tx_ack_en_n,
  input  logic        tx_ack_n
);
  localparam int NUM_LANES = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic [6:0] addr;
    logic [2:0] len;
    logic [7:0] data;
  } lane_req_t;

  logic [1:0]                  state;
  logic [3:0]                  remaining;
  logic                        prio;
  logic [NUM_LANES-1:0]        win;
  logic [NUM_LANES-1:0]        fsel;
  logic [NUM_LANES-1:0][17:0]  lane_fields;
  logic [17:0]                 fields_or;
  lane_req_t                   cur;
  logic                        xfer;
  logic                        ack_ok;
  logic                        pop_en;
  logic                        done_en;
  logic                        wd_expire;

  // prio names the requester that wins a tie.
  always_comb begin
    win = '0;
    if (req[0] && req[1]) win = prio ? 2'b10 : 2'b01;
    else if (req[0])      win = 2'b01;
    else if (req[1])      win = 2'b10;
  end

  assign fsel    = (state == S_IDLE) ? win : gnt;
  assign xfer    = (state == S_ADDR) || (state == S_DATA);
  assign ack_ok  = xfer && !tx_ack_en_n && !tx_ack_n;
  assign pop_en  = ack_ok && (remaining != 4'd0);
  assign done_en = (state == S_DONE);
  assign busy    = |gnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    i2c_tx_sched_lane u_lane (
      .gsel    (gnt[i]),
      .fsel    (fsel[i]),
      .pop_en  (pop_en),
      .done_en (done_en),
      .addr    (addr[7*i +: 7]),
      .len     (len[3*i +: 3]),
      .pdata   (pdata[8*i +: 8]),
      .fields  (lane_fields[i]),
      .pop     (pop[i]),
      .done    (done[i])
    );
  end

  always_comb begin
    fields_or = '0;
    for (int i = 0; i < NUM_LANES; i++) fields_or = fields_or | lane_fields[i];
  end
  assign cur = fields_or;

`ifdef I2C_TX_SCHED_TIMEOUT_EN
  logic [7:0] wd_cnt;

  assign wd_expire = xfer && tx_ack_en_n && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Restarts at every byte start: entry into ADDR and every pop.
  always_ff @(posedge clk) begin
    if (!rstn || (state == S_IDLE) || pop_en) wd_cnt <= '0;
    else if (xfer && tx_ack_en_n)             wd_cnt <= wd_cnt + 8'd1;
  end
`else
  logic unused_timeout;

  assign wd_expire      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      gnt       <= '0;
      status    <= 2'b00;
      tx_n      <= 1'b1;
      tx_data   <= 8'hFF;
      remaining <= '0;
      prio      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt       <= win;
            tx_n      <= 1'b0;
            tx_data   <= {cur.addr, 1'b0};
            remaining <= {1'b0, cur.len} + 4'd1;
            state     <= S_ADDR;
          end
        end
        S_ADDR, S_DATA: begin
          if (!tx_ack_en_n) begin
            if (tx_ack_n) begin
              status <= (state == S_ADDR) ? 2'b01 : 2'b10;
              tx_n   <= 1'b1;
              state  <= S_DONE;
            end else if (remaining != 4'd0) begin
              tx_data   <= cur.data;
              remaining <= remaining - 4'd1;
              state     <= S_DATA;
            end else begin
              status <= 2'b00;
              tx_n   <= 1'b1;
              state  <= S_DONE;
            end
          end else if (wd_expire) begin
            status <= 2'b11;
            tx_n   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          prio  <= gnt[0];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_tx_sched.sv
// Scoreboard bench for i2c_tx_sched: expected bytes/results queued at stimulus, checked at ack/done.
module tb_i2c_tx_sched;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [13:0] addr;
  logic [5:0]  len;
  logic [15:0] pdata;
  logic [1:0]  pop, gnt, done, status;
  logic        busy, tx_n;
  logic [7:0]  tx_data;
  logic        tx_ack_en_n = 1'b1;
  logic        tx_ack_n = 1'b1;

  logic [6:0]  ad [2];
  logic [2:0]  ln [2];
  logic [7:0]  pay [2][8];
  logic [2:0]  pcnt0 = 3'd0, pcnt1 = 3'd0, pb0 = 3'd0, pb1 = 3'd0, pi0, pi1;

  typedef struct {
    logic [1:0] g;
    logic [1:0] st;
    int         pops;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] exp_b[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign addr  = {ad[1], ad[0]};
  assign len   = {ln[1], ln[0]};
  assign pi0   = pcnt0 - pb0;
  assign pi1   = pcnt1 - pb1;
  assign pdata = {pay[1][pi1], pay[0][pi0]};

  // First-word-fall-through source: a pop advances to the next byte.
  always @(posedge clk) begin
    if (pop[0]) pcnt0 <= pcnt0 + 3'd1;
    if (pop[1]) pcnt1 <= pcnt1 + 3'd1;
  end

  i2c_tx_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .addr(addr), .len(len), .pdata(pdata),
    .pop(pop), .gnt(gnt), .done(done), .status(status), .busy(busy),
    .tx_n(tx_n), .tx_data(tx_data), .tx_ack_en_n(tx_ack_en_n), .tx_ack_n(tx_ack_n)
  );

  task automatic do_reset;
    rstn = 1'b0; req = 2'b00; tx_ack_en_n = 1'b1; tx_ack_n = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic prep(input int l, input logic [6:0] a, input logic [2:0] n, input int nak_at);
    res_t r;
    int   nb;
    ad[l] = a;
    ln[l] = n;
    if (l == 0) pb0 = pcnt0; else pb1 = pcnt1;
    nb = (nak_at < 0) ? int'(n) + 2 : nak_at + 1;
    exp_b.push_back({a, 1'b0});
    for (int k = 1; k < nb; k++) exp_b.push_back(pay[l][k-1]);
    r.g    = (l == 0) ? 2'b01 : 2'b10;
    r.st   = (nak_at < 0) ? 2'b00 : (nak_at == 0) ? 2'b01 : 2'b10;
    r.pops = (nak_at < 0) ? int'(n) + 1 : nak_at;
    exp_q.push_back(r);
  endtask

  // Acts as the byte transmitter: acks each byte after dly cycles, NAKs byte nak_at.
  task automatic run(input string tag, input logic [1:0] r, input int nak_at, input int dly,
                     input int n_txn, input int abort_pops, input bit drop);
    int   ndone = 0, wcnt = 0, bidx = 0, npop = 0, cyc = 0;
    bit   aborted = 0;
    logic prev_tx = tx_n, prev_busy = busy;
    res_t e;
    logic [7:0] eb;
    req = r;
    while (ndone < n_txn && !aborted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) begin
        checks++;
        if (prev_tx !== 1'b1) $display("FAIL %s_gap tx_n before grant got %b exp 1", tag, prev_tx);
        else passes++;
        checks++;
        if (exp_q.size() == 0) $display("FAIL %s_grant unexpected grant %b", tag, gnt);
        else if (gnt !== exp_q[0].g) $display("FAIL %s_grant got %b exp %b", tag, gnt, exp_q[0].g);
        else passes++;
      end
      if (done !== 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL %s_done unexpected done %b", tag, done);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (done !== e.g) $display("FAIL %s_done got %b exp %b", tag, done, e.g); else passes++;
          checks++;
          if (status !== e.st) $display("FAIL %s_status got %b exp %b", tag, status, e.st); else passes++;
          checks++;
          if (npop !== e.pops) $display("FAIL %s_pops got %0d exp %0d", tag, npop, e.pops); else passes++;
          checks++;
          if (tx_n !== 1'b1) $display("FAIL %s_done_tx_n got %b exp 1", tag, tx_n); else passes++;
        end
        req = req & ~done;
        ndone++; npop = 0; bidx = 0; wcnt = 0;
      end
      tx_ack_en_n = 1'b1;
      tx_ack_n    = 1'b1;
      if (!tx_n && busy) begin
        if (wcnt >= dly) begin
          tx_ack_en_n = 1'b0;
          tx_ack_n    = (bidx == nak_at);
          checks++;
          if (exp_b.size() == 0) $display("FAIL %s_byte unexpected byte %h", tag, tx_data);
          else begin
            eb = exp_b.pop_front();
            if (tx_data !== eb) $display("FAIL %s_byte%0d got %h exp %h", tag, bidx, tx_data, eb);
            else passes++;
          end
          bidx++; wcnt = 0;
        end else wcnt++;
      end
      #1;
      if (pop !== 2'b00) begin
        checks++;
        if (pop !== gnt) $display("FAIL %s_pop_lane got %b exp %b", tag, pop, gnt); else passes++;
        npop++;
        if (drop && npop == 1) req = 2'b00;
        if (npop == abort_pops) aborted = 1;
      end
      prev_tx   = tx_n;
      prev_busy = busy;
    end
    if (!aborted && ndone < n_txn) begin
      checks++;
      $display("FAIL %s_timeout done count got %0d exp %0d", tag, ndone, n_txn);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (tx_n !== 1'b1)     $display("FAIL rst_tx_n got %b exp 1", tx_n);        else passes++;
    checks++; if (tx_data !== 8'hFF) $display("FAIL rst_tx_data got %h exp ff", tx_data); else passes++;
    checks++; if (gnt !== 2'b00)     $display("FAIL rst_gnt got %b exp 00", gnt);         else passes++;
    checks++; if (busy !== 1'b0)     $display("FAIL rst_busy got %b exp 0", busy);        else passes++;
    checks++; if (done !== 2'b00)    $display("FAIL rst_done got %b exp 00", done);       else passes++;
    checks++; if (status !== 2'b00)  $display("FAIL rst_status got %b exp 00", status);   else passes++;
    checks++; if (pop !== 2'b00)     $display("FAIL rst_pop got %b exp 00", pop);         else passes++;
  endtask

  task automatic test_basic;
    res_t r;
    pay[0][0] = 8'hA1; pay[0][1] = 8'hB2; pay[0][2] = 8'hC3;
    ad[0] = 7'h50; ln[0] = 3'd2; pb0 = pcnt0;
    exp_b.push_back(8'hA0); exp_b.push_back(8'hA1); exp_b.push_back(8'hB2); exp_b.push_back(8'hC3);
    r.g = 2'b01; r.st = 2'b00; r.pops = 3;
    exp_q.push_back(r);
    run("basic", 2'b01, -1, 0, 1, -1, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b0)  $display("FAIL basic_busy_clear got %b exp 0", busy); else passes++;
    checks++; if (gnt !== 2'b00)  $display("FAIL basic_gnt_clear got %b exp 00", gnt); else passes++;
  endtask

  task automatic test_back_to_back;
    do_reset;
    pay[0][0] = 8'h5A;
    pay[1][0] = 8'h11; pay[1][1] = 8'h22; pay[1][2] = 8'h33; pay[1][3] = 8'h44;
    prep(0, 7'h21, 3'd0, -1);
    prep(1, 7'h3C, 3'd3, -1);
    run("b2b", 2'b11, -1, 1, 2, -1, 0);
  endtask

  task automatic test_data_nak;
    pay[1][0] = 8'h9A; pay[1][1] = 8'h9B; pay[1][2] = 8'h9C;
    prep(1, 7'h0F, 3'd4, 1);
    run("data_nak", 2'b10, 1, 1, 1, -1, 0);
  endtask

  task automatic test_addr_nak;
    pay[0][0] = 8'hE1;
    prep(0, 7'h7E, 3'd1, 0);
    run("addr_nak", 2'b01, 0, 2, 1, -1, 0);
  endtask

  task automatic test_req_drop;
    pay[0][0] = 8'h01; pay[0][1] = 8'h02; pay[0][2] = 8'h03; pay[0][3] = 8'h04;
    prep(0, 7'h44, 3'd3, -1);
    run("req_drop", 2'b01, -1, 0, 1, -1, 1);
  endtask

  task automatic test_timeout;
    int n = 0, cyc = 0;
    ad[0] = 7'h33; ln[0] = 3'd0; pay[0][0] = 8'h77; pb0 = pcnt0;
    tx_ack_en_n = 1'b1; tx_ack_n = 1'b1; req = 2'b01;
    do begin @(negedge clk); n++; end while (!busy && n < 10);
    while (done === 2'b00 && cyc < 60) begin @(negedge clk); cyc++; end
`ifdef I2C_TX_SCHED_TIMEOUT_EN
    checks++; if (done !== 2'b01)   $display("FAIL tmo_done got %b exp 01", done);     else passes++;
    checks++; if (status !== 2'b11) $display("FAIL tmo_status got %b exp 11", status); else passes++;
    checks++; if (cyc !== TMO)      $display("FAIL tmo_cycles got %0d exp %0d", cyc, TMO); else passes++;
`else
    checks++; if (busy !== 1'b1)    $display("FAIL tmo_busy_hold got %b exp 1", busy); else passes++;
    checks++; if (done !== 2'b00)   $display("FAIL tmo_no_done got %b exp 00", done);  else passes++;
    checks++; if (tx_n !== 1'b0)    $display("FAIL tmo_tx_n_hold got %b exp 0", tx_n); else passes++;
`endif
    req = 2'b00;
    do_reset;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 8; k++) pay[0][k] = 8'(8'h10 + k);
    prep(0, 7'h2A, 3'd7, -1);
    run("rst_mid", 2'b01, -1, 1, 1, 3, 0);
    rstn = 1'b0; req = 2'b00; tx_ack_en_n = 1'b1; tx_ack_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_n !== 1'b1)     $display("FAIL rst_mid_tx_n got %b exp 1", tx_n);        else passes++;
    checks++; if (tx_data !== 8'hFF) $display("FAIL rst_mid_tx_data got %h exp ff", tx_data); else passes++;
    checks++; if (gnt !== 2'b00)     $display("FAIL rst_mid_gnt got %b exp 00", gnt);         else passes++;
    checks++; if (busy !== 1'b0)     $display("FAIL rst_mid_busy got %b exp 0", busy);        else passes++;
    checks++; if (done !== 2'b00)    $display("FAIL rst_mid_done got %b exp 00", done);       else passes++;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (done !== 2'b00) $display("FAIL rst_mid_late_done got %b exp 00", done); else passes++;
    end
    exp_q.delete();
    exp_b.delete();
    pay[1][0] = 8'hC7; pay[1][1] = 8'hD8;
    prep(1, 7'h11, 3'd1, -1);
    run("after_rst", 2'b10, -1, 0, 1, -1, 0);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      ad[l] = '0;
      ln[l] = '0;
      for (int k = 0; k < 8; k++) pay[l][k] = '0;
    end
    test_reset;
    test_basic;
    test_back_to_back;
    test_data_nak;
    test_addr_nak;
    test_req_drop;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
